// File: rtl/predelay_line_ctrl_if.sv
// Sample-RAM port bundle for the reverb pre-delay controller.
// master = controller side (drives address/write), slave = RAM side (returns read data).
interface predelay_line_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (output ram_addr, ram_we, ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/predelay_line_ctrl.sv
// Reverb pre-delay sequencer: write sample, read back cur_delay samples old, emit it.
// Define PREDELAY_SLEW_EN to slew cur_delay one step per sample toward target_delay.
module predelay_line_ctrl #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 10,
    parameter int RAM_RD_LAT  = 2,
    parameter int RESET_DELAY = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   target_delay,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_in,
    predelay_line_ctrl_if.master ram,
    output logic [DATA_W-1:0]   sample_out,
    output logic                sample_out_valid,
    output logic [ADDR_W-1:0]   cur_delay,
    output logic                busy,
    output logic                overrun
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_OUT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [2:0]        wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            wr_ptr           <= '0;
            fill_cnt         <= '0;
            wait_cnt         <= '0;
            cur_delay        <= ADDR_W'(RESET_DELAY);
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            ram.ram_we       <= 1'b0;
            ram.ram_addr     <= '0;
            ram.ram_wdata    <= '0;
        end else begin
            sample_out_valid <= 1'b0;
            // A strobe arriving mid-sequence is dropped; the running sequence is untouched.
            overrun          <= sample_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        state         <= S_WR;
                        busy          <= 1'b1;
                        ram.ram_we    <= 1'b1;
                        ram.ram_addr  <= wr_ptr;
                        ram.ram_wdata <= sample_in;
                    end
                end
                S_WR: begin
                    state        <= S_RD;
                    ram.ram_we   <= 1'b0;
                    ram.ram_addr <= wr_ptr - cur_delay;
                    wait_cnt     <= '0;
                end
                S_RD: state <= S_WAIT;
                S_WAIT: begin
                    if (wait_cnt == 3'(RAM_RD_LAT - 1)) begin
                        state            <= S_OUT;
                        // Unprimed slot: the RAM word there was never written since reset.
                        sample_out       <= (cur_delay > fill_cnt) ? '0 : ram.ram_rdata;
                        sample_out_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_OUT: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill_cnt != '1)
                        fill_cnt <= fill_cnt + 1'b1;
`ifdef PREDELAY_SLEW_EN
                    if (cur_delay < target_delay)
                        cur_delay <= cur_delay + 1'b1;
                    else if (cur_delay > target_delay)
                        cur_delay <= cur_delay - 1'b1;
`else
                    cur_delay <= target_delay;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_predelay_line_ctrl.sv
// Directed bench for predelay_line_ctrl: sample-history model checked every cycle,
// plus literal expectations per scenario.
module tb_predelay_line_ctrl;
    localparam int DW  = 24;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] target_delay = 10'd5;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] sample_out;
    logic          sample_out_valid;
    logic [AW-1:0] cur_delay;
    logic          busy;
    logic          overrun;

    predelay_line_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

    predelay_line_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RAM_RD_LAT(LAT), .RESET_DELAY(5)) dut (
        .clk(clk), .reset(rst), .target_delay(target_delay),
        .sample_valid(sample_valid), .sample_in(sample_in), .ram(ram_if),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .cur_delay(cur_delay), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // External RAM with LAT-cycle read latency, preloaded with junk so stale reads show up.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe [LAT];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 24'hBAD000 ^ 24'(i);
    always @(posedge clk) begin
        if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
        rd_pipe[0] <= mem[ram_if.ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_if.ram_rdata = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: every accepted sample k is appended to hist; its output is hist[k-d] or 0 when d > k.
    logic [DW-1:0] hist[$];
    int            acc_cyc = -100;
    int            out_cyc = -1;
    int            ovr_cyc = -1;
    int            k = 0;
    int            d = 5;
    logic [DW-1:0] out_val = '0;
    logic [DW-1:0] last_out = '0;
    bit            ev;
    bit            in_seq;
    int            wr_idx;

    always @(negedge clk) begin
        if (rst) begin
            hist.delete();
            acc_cyc = -100; out_cyc = -1; ovr_cyc = -1; k = 0; d = 5; last_out = '0;
            chk("rst_out_valid", 32'(sample_out_valid), 32'd0);
            chk("rst_sample_out", 32'(sample_out), 32'd0);
            chk("rst_cur_delay", 32'(cur_delay), 32'd5);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_overrun", 32'(overrun), 32'd0);
            chk("rst_ram_we", 32'(ram_if.ram_we), 32'd0);
            chk("rst_ram_addr", 32'(ram_if.ram_addr), 32'd0);
            chk("rst_ram_wdata", 32'(ram_if.ram_wdata), 32'd0);
        end else begin
            ev     = (cyc == out_cyc);
            in_seq = (cyc > acc_cyc) && (cyc <= acc_cyc + 3 + LAT);
            chk("out_valid", 32'(sample_out_valid), 32'(ev));
            if (ev) last_out = out_val;
            chk("sample_out", 32'(sample_out), 32'(last_out));
            chk("busy", 32'(busy), 32'(in_seq));
            chk("overrun", 32'(overrun), 32'(cyc == ovr_cyc));
            chk("cur_delay", 32'(cur_delay), 32'(d));
            chk("ram_we", 32'(ram_if.ram_we), 32'(cyc == acc_cyc + 1));
            wr_idx = (k - 1) % DEPTH;
            if (cyc == acc_cyc + 1) begin
                chk("wr_addr", 32'(ram_if.ram_addr), 32'(wr_idx));
                chk("wr_data", 32'(ram_if.ram_wdata), 32'(hist[k-1]));
            end
            if (cyc == acc_cyc + 2)
                chk("rd_addr", 32'(ram_if.ram_addr), 32'((wr_idx - d + DEPTH) % DEPTH));
            if (ev) begin
`ifdef PREDELAY_SLEW_EN
                if (d < int'(target_delay)) d = d + 1;
                else if (d > int'(target_delay)) d = d - 1;
`else
                d = int'(target_delay);
`endif
            end
            if (sample_valid) begin
                if (in_seq) ovr_cyc = cyc + 1;
                else begin
                    acc_cyc = cyc;
                    hist.push_back(sample_in);
                    out_val = (d > k) ? '0 : hist[k-d];
                    out_cyc = cyc + 3 + LAT;
                    k++;
                end
            end
        end
    end

    // Raw DUT observations for the literal scenario checks.
    logic [DW-1:0] outs[$];
    int            lats[$];
    int            strobe_cyc = 0;
    int            ovr_cnt = 0;
    int            busy_cnt = 0;
    always @(negedge clk) begin
        if (!rst && sample_out_valid) begin
            outs.push_back(sample_out);
            lats.push_back(cyc - strobe_cyc);
        end
        if (overrun) ovr_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic send(input logic [DW-1:0] v, input int gap);
        @(posedge clk); #1;
        sample_valid = 1'b1; sample_in = v; strobe_cyc = cyc;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    localparam int FAST = 2 + LAT;  // back-to-back at full throughput
    localparam int SLOW = 3 + LAT;  // returns just after cur_delay has updated

    logic [DW-1:0] t1_exp [20] = '{0,0,0,0,0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
`ifdef PREDELAY_SLEW_EN
    logic [AW-1:0] t5_exp [4] = '{10'd6, 10'd7, 10'd8, 10'd9};
`else
    logic [AW-1:0] t5_exp [4] = '{10'd9, 10'd9, 10'd9, 10'd9};
`endif

    int nz;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: delay 5 from reset, 20 samples at full rate
        outs.delete(); lats.delete();
        for (int i = 1; i <= 20; i++) send(DW'(i), FAST);
        repeat (4) @(posedge clk);
        chk("t1_count", 32'(outs.size()), 32'd20);
        for (int i = 0; i < 20 && i < outs.size(); i++) begin
            chk("t1_out", 32'(outs[i]), 32'(t1_exp[i]));
            chk("t1_latency", 32'(lats[i]), 32'd5);
        end

        // 2: zero delay is pass-through
        target_delay = 10'd0;
        for (int i = 0; i < 6; i++) send(24'hEEE000 + DW'(i), SLOW);
        chk("t2_cur_delay", 32'(cur_delay), 32'd0);
        outs.delete();
        for (int i = 0; i < 8; i++) send(24'h100000 + DW'(i * 24'h1111), SLOW);
        chk("t2_count", 32'(outs.size()), 32'd8);
        for (int i = 0; i < 8 && i < outs.size(); i++)
            chk("t2_out", 32'(outs[i]), 32'(24'h100000 + DW'(i * 24'h1111)));

        // 4: strobe two cycles into a sequence is dropped
        outs.delete(); ovr_cnt = 0; busy_cnt = 0;
        @(posedge clk); #1 sample_valid = 1'b1; sample_in = 24'hA5A5A5; strobe_cyc = cyc;
        @(posedge clk); #1 sample_valid = 1'b0;
        @(posedge clk); #1 sample_valid = 1'b1; sample_in = 24'h5A5A5A;
        @(posedge clk); #1 sample_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_overrun_pulses", 32'(ovr_cnt), 32'd1);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'(3 + LAT));
        chk("t4_count", 32'(outs.size()), 32'd1);
        if (outs.size() > 0) chk("t4_out", 32'(outs[0]), 32'h00A5A5A5);

        // 5: target step 5 -> 9
        target_delay = 10'd5;
        for (int i = 0; i < 6; i++) send(DW'(i), SLOW);
        chk("t5_settled", 32'(cur_delay), 32'd5);
        target_delay = 10'd9;
        for (int i = 0; i < 4; i++) begin
            send(DW'(i), SLOW);
            chk("t5_cur_delay", 32'(cur_delay), 32'(t5_exp[i]));
        end

        // 3: maximum delay across the pointer wrap
        pulse_reset();
        target_delay = 10'd1023;
        outs.delete();
        for (int n = 0; n < 1030; n++) send(DW'(n + 1), FAST);
        repeat (4) @(posedge clk);
        chk("t3_count", 32'(outs.size()), 32'd1030);
        if (outs.size() == 1030) begin
            nz = 0;
            for (int n = 0; n < 1023; n++) if (outs[n] != '0) nz++;
            chk("t3_unprimed_zero", 32'(nz), 32'd0);
            chk("t3_out1023", 32'(outs[1023]), 32'd1);
            chk("t3_out1024", 32'(outs[1024]), 32'd2);
            chk("t3_out1029", 32'(outs[1029]), 32'd7);
        end

        // 6: reset while waiting on the RAM
        outs.delete();
        @(posedge clk); #1 sample_valid = 1'b1; sample_in = 24'hABCDEF;
        @(posedge clk); #1 sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_sample_out", 32'(sample_out), 32'd0);
        chk("t6_rst_cur_delay", 32'(cur_delay), 32'd5);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ram_we", 32'(ram_if.ram_we), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_strobe", 32'(outs.size()), 32'd0);
        target_delay = 10'd5;
        send(24'h123456, SLOW);
        chk("t6_count", 32'(outs.size()), 32'd1);
        if (outs.size() > 0) chk("t6_first_out", 32'(outs[0]), 32'd0);
        chk("t6_cur_delay", 32'(cur_delay), 32'd5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
